// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operation request and result bundle for alu_exec_unit.
// master issues operations; slave (the unit) returns registered results and HI/LO.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             illegal;

    modport master (
        output valid_in, ALUOp, funct, a, b,
        input  ready_out, valid_out, result, zero, overflow, hi, lo, illegal
    );
    modport slave (
        input  valid_in, ALUOp, funct, a, b,
        output ready_out, valid_out, result, zero, overflow, hi, lo, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALUOp/funct decode with a registered ALU, iterative mul/div and HI/LO.
// Single-cycle ops complete back-to-back; mul/div hold ready_out low for WIDTH+1 cycles.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave io
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a, b, sum, dif, res_c, abs_a, abs_b;
    logic [WIDTH-1:0]   acc, sh, mc, acc_nx, sh_nx, fin_hi, fin_lo;
    logic [WIDTH-1:0]   result, hi, lo;
    logic [WIDTH:0]     add_s, shl, sub_s;
    logic [2*WIDTH-1:0] prod, prod_c;
    logic [CNT_W-1:0]   cnt;
    logic go, ready, ov_add, ov_sub, ov_c, ill_c, md_c, mul_c, sgn_c;
    logic is_mul, neg_p, neg_r, div0, valid, zero, overflow, illegal;

    assign a      = io.a;
    assign b      = io.b;
    assign sum    = a + b;
    assign dif    = a - b;
    assign ov_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign ov_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    assign mul_c  = ~io.funct[1];
    assign sgn_c  = ~io.funct[0];
    assign abs_a  = (sgn_c && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (sgn_c && b[WIDTH-1]) ? -b : b;
    assign go     = io.valid_in && ready;

    always_comb begin
        res_c = '0;
        ov_c  = 1'b0;
        ill_c = 1'b0;
        md_c  = 1'b0;
        case (io.ALUOp)
            2'b00: begin res_c = sum; ov_c = ov_add; end
            2'b01: begin res_c = dif; ov_c = ov_sub; end
            2'b11: res_c = a | b;
            default: case (io.funct)
                6'b100000: begin res_c = sum; ov_c = ov_add; end
                6'b100001: res_c = sum;
                6'b100010: begin res_c = dif; ov_c = ov_sub; end
                6'b100011: res_c = dif;
                6'b100100: res_c = a & b;
                6'b100101: res_c = a | b;
                6'b100110: res_c = a ^ b;
                6'b100111: res_c = ~(a | b);
                6'b101010: res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                6'b101011: res_c = {{(WIDTH-1){1'b0}}, a < b};
                6'b010000: res_c = hi;
                6'b010010: res_c = lo;
                6'b011000, 6'b011001, 6'b011010, 6'b011011: md_c = 1'b1;
                default: ill_c = 1'b1;
            endcase
        endcase
    end

    // Multiply shifts {acc,sh} right with a conditional add; divide shifts the
    // dividend out of sh into acc and shifts quotient bits into sh.
    assign add_s  = {1'b0, acc} + (sh[0] ? {1'b0, mc} : '0);
    assign shl    = {acc, sh[WIDTH-1]};
    assign sub_s  = shl - {1'b0, mc};
    assign acc_nx = is_mul ? add_s[WIDTH:1] : (sub_s[WIDTH] ? shl[WIDTH-1:0] : sub_s[WIDTH-1:0]);
    assign sh_nx  = is_mul ? {add_s[0], sh[WIDTH-1:1]} : {sh[WIDTH-2:0], ~sub_s[WIDTH]};
    assign prod   = {acc_nx, sh_nx};
    assign prod_c = neg_p ? -prod : prod;
    assign fin_hi = is_mul ? prod_c[2*WIDTH-1:WIDTH] : (neg_r ? -acc_nx : acc_nx);
    assign fin_lo = is_mul ? prod_c[WIDTH-1:0] : (div0 ? '1 : (neg_p ? -sh_nx : sh_nx));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (io.valid_in && md_c)
                    state_nx = RUN;
            end
            RUN: if (cnt == CNT_W'(1)) state_nx = FINISH;
            default: state_nx = IDLE;
        endcase
    end

    // The last iteration and sign correction share one edge so FINISH already shows the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            sh       <= '0;
            mc       <= '0;
            cnt      <= '0;
            is_mul   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (go && !md_c) begin
                valid    <= 1'b1;
                result   <= res_c;
                zero     <= res_c == '0;
                overflow <= ov_c;
                illegal  <= ill_c;
            end
            if (go && md_c) begin
                acc    <= '0;
                sh     <= abs_a;
                mc     <= abs_b;
                cnt    <= CNT_W'(WIDTH);
                is_mul <= mul_c;
                neg_p  <= sgn_c && (a[WIDTH-1] ^ b[WIDTH-1]) && (mul_c || b != '0);
                neg_r  <= sgn_c && !mul_c && a[WIDTH-1];
                div0   <= !mul_c && b == '0;
            end
            if (state == RUN) begin
                acc <= acc_nx;
                sh  <= sh_nx;
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    valid    <= 1'b1;
                    hi       <= fin_hi;
                    lo       <= fin_lo;
                    result   <= fin_lo;
                    zero     <= fin_lo == '0;
                    overflow <= 1'b0;
                    illegal  <= 1'b0;
                end
            end
        end
    end

    assign io.ready_out = ready;
    assign io.valid_out = valid;
    assign io.result    = result;
    assign io.zero      = zero;
    assign io.overflow  = overflow;
    assign io.illegal   = illegal;
    assign io.hi        = hi;
    assign io.lo        = lo;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit at WIDTH=32 and WIDTH=8.
// Expected responses come from a wide-integer arithmetic model; a negedge monitor pops and compares.
module tb_alu_exec_unit;
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cyc;
        logic        z;
        logic        ov;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc = '0;
    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];
    logic [5:0]  fl [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};

    alu_exec_unit_if #(.WIDTH(32)) io32 ();
    alu_exec_unit_if #(.WIDTH(8))  io8 ();
    alu_exec_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .io(io32.slave));
    alu_exec_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .io(io8.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Reference: MIPS semantics evaluated on 64-bit integers, then truncated to the unit width.
    function automatic exp_t model(input int s, input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int w;
        logic [5:0] f;
        logic [63:0] m, p;
        longint sa, sb, mx, r, q;
        longint unsigned ua, ub;
        w  = s != 0 ? 8 : 32;
        m  = (64'd1 << w) - 64'd1;
        mx = longint'(m >> 1);
        ua = {32'b0, a} & m;
        ub = {32'b0, b} & m;
        sa = ua[w-1] ? longint'(ua) - longint'(m) - 64'sd1 : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(m) - 64'sd1 : longint'(ub);
        f  = op == 2'b00 ? 6'h20 : op == 2'b01 ? 6'h22 : op == 2'b11 ? 6'h25 : fn;
        e = '0;
        e.tag = {op, fn};
        p = '0;
        case (f)
            6'h20, 6'h21: begin
                r = sa + sb;
                p = r;
                e.ov = f == 6'h20 && (r > mx || r < -mx - 64'sd1);
            end
            6'h22, 6'h23: begin
                r = sa - sb;
                p = r;
                e.ov = f == 6'h22 && (r > mx || r < -mx - 64'sd1);
            end
            6'h24: p = ua & ub;
            6'h25: p = ua | ub;
            6'h26: p = ua ^ ub;
            6'h27: p = ~(ua | ub);
            6'h2A: p = {63'b0, sa < sb};
            6'h2B: p = {63'b0, ua < ub};
            6'h10: p = {32'b0, mhi[s]};
            6'h12: p = {32'b0, mlo[s]};
            6'h18, 6'h19: begin
                if (f == 6'h18) p = sa * sb;
                else p = ua * ub;
                mhi[s] = 32'((p >> w) & m);
                mlo[s] = 32'(p & m);
                e.cyc = 32'(w);
                p = {32'b0, mlo[s]};
            end
            6'h1A, 6'h1B: begin
                if (ub == '0) begin
                    q = longint'(m);
                    r = longint'(ua);
                end else if (f == 6'h1A) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                mhi[s] = 32'(r & m);
                mlo[s] = 32'(q & m);
                e.cyc = 32'(w);
                p = {32'b0, mlo[s]};
            end
            default: e.ill = 1'b1;
        endcase
        e.res = 32'(p & m);
        e.z   = e.res == '0;
        e.hi  = mhi[s];
        e.lo  = mlo[s];
        return e;
    endfunction

    function automatic logic [31:0] rnd(input int s);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = s != 0 ? 32'h80 : 32'h8000_0000;
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return s != 0 ? v & 32'hFF : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check(input int s, input logic [31:0] res, input logic [31:0] hi, input logic [31:0] lo,
                         input logic z, input logic ov, input logic il);
        exp_t e;
        n_cmp++;
        if ((s != 0 ? q8.size() : q32.size()) == 0) begin
            n_fail++;
            $display("FAIL w%0d unexpected valid_out at cycle %0d: result=%h hi=%h lo=%h",
                     s != 0 ? 8 : 32, cyc, res, hi, lo);
            return;
        end
        if (s != 0) e = q8.pop_front();
        else e = q32.pop_front();
        if ({res, hi, lo, z, ov, il} !== {e.res, e.hi, e.lo, e.z, e.ov, e.ill} || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL w%0d op=%h: got result=%h hi=%h lo=%h zero=%b ovf=%b ill=%b cycle=%0d, expected result=%h hi=%h lo=%h zero=%b ovf=%b ill=%b cycle=%0d",
                     s != 0 ? 8 : 32, e.tag, res, hi, lo, z, ov, il, cyc,
                     e.res, e.hi, e.lo, e.z, e.ov, e.ill, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (io32.valid_out)
            check(0, io32.result, io32.hi, io32.lo, io32.zero, io32.overflow, io32.illegal);
        if (io8.valid_out)
            check(1, {24'b0, io8.result}, {24'b0, io8.hi}, {24'b0, io8.lo}, io8.zero, io8.overflow, io8.illegal);
    end

    task automatic drive(input int s, input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        if (s != 0) begin
            io8.valid_in = v;
            io8.ALUOp    = op;
            io8.funct    = fn;
            io8.a        = a[7:0];
            io8.b        = b[7:0];
        end else begin
            io32.valid_in = v;
            io32.ALUOp    = op;
            io32.funct    = fn;
            io32.a        = a;
            io32.b        = b;
        end
    endtask

    // Holds valid_in until ready_out is seen, then scores the op against the accepting edge.
    task automatic issue(input int s, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n = 0;
        @(negedge clk);
        drive(s, 1'b1, op, fn, a, b);
        while (!(s != 0 ? io8.ready_out : io32.ready_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept w%0d op=%h: ready_out never returned", s != 0 ? 8 : 32, {op, fn});
        end else begin
            e = model(s, op, fn, a, b);
            e.cyc = e.cyc + cyc + 32'd1;
            if (s != 0) q8.push_back(e);
            else q32.push_back(e);
        end
        @(posedge clk);
        #1 drive(s, 1'b0, op, fn, a, b);
    endtask

    task automatic reset_state(input int s, input string tag);
        if (s != 0) begin
            chk({tag, " flags w8"}, {27'b0, io8.ready_out, io8.valid_out, io8.zero, io8.overflow, io8.illegal}, 32'b10100);
            chk({tag, " hi/lo/result w8"}, {8'b0, io8.hi, io8.lo, io8.result}, 32'h0);
        end else begin
            chk({tag, " flags w32"}, {27'b0, io32.ready_out, io32.valid_out, io32.zero, io32.overflow, io32.illegal}, 32'b10100);
            chk({tag, " result w32"}, io32.result, 32'h0);
            chk({tag, " hi w32"}, io32.hi, 32'h0);
            chk({tag, " lo w32"}, io32.lo, 32'h0);
        end
    endtask

    task automatic directed(input int s);
        logic [31:0] m, mn;
        m  = s != 0 ? 32'hFF : 32'hFFFF_FFFF;
        mn = s != 0 ? 32'h80 : 32'h8000_0000;
        issue(s, 2'b00, 6'h00, mn - 1, 1);
        issue(s, 2'b01, 6'h00, 5, 5);
        issue(s, 2'b10, 6'h18, m - 1, 3);
        @(negedge clk);
        chk("ready_out low while busy", {31'b0, s != 0 ? io8.ready_out : io32.ready_out}, 32'h0);
        issue(s, 2'b10, 6'h19, m - 1, 3);
        issue(s, 2'b10, 6'h1A, m - 6, 2);
        issue(s, 2'b10, 6'h1B, 7, 0);
        issue(s, 2'b10, 6'h1A, mn, m);
        issue(s, 2'b10, 6'h1A, m - 6, 0);
        issue(s, 2'b10, 6'h18, 7, 9);
        issue(s, 2'b00, 6'h00, 3, 4);
        issue(s, 2'b10, 6'h12, 0, 0);
        issue(s, 2'b10, 6'h10, 0, 0);
        issue(s, 2'b10, 6'h2A, m, 1);
        issue(s, 2'b10, 6'h2B, m, 1);
        issue(s, 2'b10, 6'h27, 0, 0);
        issue(s, 2'b10, 6'h3F, 12, 34);
        issue(s, 2'b11, 6'h00, 32'h0F, 32'hF0);
        issue(s, 2'b10, 6'h21, mn - 1, 1);
        issue(s, 2'b10, 6'h22, mn, 1);
    endtask

    task automatic random_ops(input int s, input int count);
        logic [1:0] op;
        logic [5:0] fn;
        int k;
        for (int i = 0; i < count; i++) begin
            op = $urandom_range(0, 5) > 2 ? 2'b10 : 2'($urandom_range(0, 3));
            k  = $urandom_range(0, 16);
            fn = k == 16 ? 6'($urandom) : fl[k];
            issue(s, op, fn, rnd(s), rnd(s));
        end
    endtask

    initial begin
        int n;
        drive(0, 1'b0, 2'b00, 6'h00, 0, 0);
        drive(1, 1'b0, 2'b00, 6'h00, 0, 0);
        for (int i = 0; i < 2; i++) begin
            mhi[i] = '0;
            mlo[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset_state(0, "reset");
        reset_state(1, "reset");
        reset = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 2'b10, 6'h18, 7, 9);
        @(posedge clk);
        #1 drive(0, 1'b0, 2'b10, 6'h18, 7, 9);
        repeat (10) @(negedge clk);
        chk("ready_out mid-run", {31'b0, io32.ready_out}, 32'h0);
        #3 reset = 1'b1;
        #1 reset_state(0, "async reset mid-run");
        @(negedge clk) reset = 1'b0;
        repeat (40) @(negedge clk);
        reset_state(0, "after aborted mult");
        directed(0);
        random_ops(0, 150);
        directed(1);
        random_ops(1, 150);
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (q32.size() + q8.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q32.size() + q8.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
